// File: rtl/lcd_pkg.sv
// Shared constants, command decode and FSM encoding for the HD44780-style LCD responder.
package lcd_pkg;

    localparam int         DDRAM_DEPTH = 32;
    localparam int         AC_W        = 5;
    localparam logic [7:0] SPACE_CHAR  = 8'h20;

    // Instruction opcodes are identified by their highest set bit.
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_SHIFT = 8'h10;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISP,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } op_t;

    function automatic op_t decode_cmd(input logic [7:0] d);
        op_t op;
        if      (|(d & CMD_DDRAM)) op = OP_DDRAM;
        else if (|(d & CMD_CGRAM)) op = OP_CGRAM;
        else if (|(d & CMD_FUNC))  op = OP_FUNC;
        else if (|(d & CMD_SHIFT)) op = OP_SHIFT;
        else if (|(d & CMD_DISP))  op = OP_DISP;
        else if (|(d & CMD_ENTRY)) op = OP_ENTRY;
        else if (|(d & CMD_HOME))  op = OP_HOME;
        else if (|(d & CMD_CLEAR)) op = OP_CLEAR;
        else                       op = OP_NOP;
        return op;
    endfunction

    // Address counter wraps modulo the DDRAM size, so line 0 col 15 steps into line 1 col 0.
    function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac, input logic inc);
        return inc ? ac + AC_W'(1) : ac - AC_W'(1);
    endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// HD44780-style parallel bus between lcd_driver (master) and lcd_responder (slave).
interface lcd_responder_if;

    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic [7:0] lcd_dout;
    logic       lcd_doe;

    modport master (
        output lcd_rs, lcd_rw, lcd_e, lcd_data,
        input  lcd_dout, lcd_doe
    );

    modport slave (
        input  lcd_rs, lcd_rw, lcd_e, lcd_data,
        output lcd_dout, lcd_doe
    );

endinterface

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus falling-edge-of-E transaction detector.
module lcd_bus_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       e_in,
    input  logic       rs_in,
    input  logic       rw_in,
    input  logic [7:0] data_in,
    output logic       e_sync,
    output logic       rs_sync,
    output logic       rw_sync,
    output logic       txn,
    output logic       txn_rs,
    output logic       txn_rw,
    output logic [7:0] txn_data
);

    logic [10:0] meta;
    logic [10:0] sync;
    logic [9:0]  held;
    logic        e_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= '0;
            sync   <= '0;
            held   <= '0;
            e_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep meta and sync as two distinct flop stages.
            meta   <= {e_in, rs_in, rw_in, data_in};
            sync   <= meta;
            e_prev <= sync[10];
            // Bus fields are captured on every cycle E is high, so the last such cycle wins.
            if (sync[10]) held <= sync[9:0];
        end
    end

    assign e_sync  = sync[10];
    assign rs_sync = sync[9];
    assign rw_sync = sync[8];

    // e_prev resets low, so a transaction needs E seen high for a cycle after reset.
    assign txn = e_prev & ~sync[10];
    assign {txn_rs, txn_rw, txn_data} = held;

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style LCD responder: decodes bus transactions into a 2x16 DDRAM and display state.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 64   // must exceed the 32-cycle fill, i.e. >= 33
) (
    input  logic            clk,
    input  logic            rst,
    lcd_responder_if.slave  bus,
    input  logic [4:0]      disp_addr,
    output logic [7:0]      disp_char,
    output logic            busy,
    output logic            disp_on,
    output logic            cursor_on,
    output logic            blink_on,
    output logic            two_line,
    output logic            overrun,
    output logic            addr_err,
    output logic [4:0]      cursor_addr
);

    localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic            e_sync, rs_sync, rw_sync;
    logic            txn, txn_rs, txn_rw;
    logic [7:0]      txn_data;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]      ddram [DDRAM_DEPTH];
    logic [AC_W-1:0] ac;
    logic            id;

    op_t             op;
    logic            wr_txn, wr_accept, wr_drop, rd_data_txn;
    logic            we;
    logic [AC_W-1:0] waddr;
    logic [7:0]      wdata;
    logic            doe;

    lcd_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .e_in     (bus.lcd_e),
        .rs_in    (bus.lcd_rs),
        .rw_in    (bus.lcd_rw),
        .data_in  (bus.lcd_data),
        .e_sync   (e_sync),
        .rs_sync  (rs_sync),
        .rw_sync  (rw_sync),
        .txn      (txn),
        .txn_rs   (txn_rs),
        .txn_rw   (txn_rw),
        .txn_data (txn_data)
    );

    assign op          = decode_cmd(txn_data);
    assign wr_txn      = txn & ~txn_rw;
    assign rd_data_txn = txn & txn_rw & txn_rs;
    assign wr_drop     = wr_txn & (state != ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign cursor_addr = ac;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves an output unassigned and infers a latch.
        state_nxt = state;
        wr_accept = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wr_txn) begin
                    wr_accept = 1'b1;
                    state_nxt = (!txn_rs && op == OP_CLEAR) ? ST_CLEAR : ST_BUSY;
                end
            end
            ST_BUSY:  if (cnt == CNT_W'(BUSY_CYCLES - 1))  state_nxt = ST_IDLE;
            ST_CLEAR: if (cnt == CNT_W'(CLEAR_CYCLES - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // cnt is the index of the current busy cycle, starting at 0 on the first busy cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           cnt <= '0;
        else if (wr_accept) cnt <= '0;
        else if (busy)      cnt <= cnt + CNT_W'(1);
    end

    // Single DDRAM write port: the clear fill and host data writes never overlap.
    always_comb begin
        we    = 1'b0;
        waddr = ac;
        wdata = txn_data;
        if (state == ST_CLEAR && cnt < CNT_W'(DDRAM_DEPTH)) begin
            we    = 1'b1;
            waddr = cnt[AC_W-1:0];
            wdata = SPACE_CHAR;
        end else if (wr_accept && txn_rs) begin
            we    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: DDRAM is a flop array rather than a RAM macro because reset must refill it at once.
            for (int i = 0; i < DDRAM_DEPTH; i++) ddram[i] <= SPACE_CHAR;
            disp_char <= SPACE_CHAR;
        end else begin
            if (we) ddram[waddr] <= wdata;
            disp_char <= (we && waddr == disp_addr) ? wdata : ddram[disp_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ac        <= '0;
            id        <= 1'b1;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            two_line  <= 1'b0;
            overrun   <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            if (wr_drop) overrun <= 1'b1;

            if (wr_accept && txn_rs) begin
                ac <= ac_step(ac, id);
            end else if (wr_accept) begin
                unique case (op)
                    OP_CLEAR: begin
                        ac <= '0;
                        id <= 1'b1;
                    end
                    OP_HOME:  ac <= '0;
                    OP_ENTRY: id <= txn_data[1];
                    OP_DISP: begin
                        disp_on   <= txn_data[2];
                        cursor_on <= txn_data[1];
                        blink_on  <= txn_data[0];
                    end
                    OP_SHIFT: if (!txn_data[3]) ac <= ac_step(ac, txn_data[2]);
                    OP_FUNC:  two_line <= txn_data[3];
                    OP_DDRAM: begin
                        if (txn_data[5:4] == 2'b00) ac <= {txn_data[6], txn_data[3:0]};
                        else                        addr_err <= 1'b1;
                    end
                    default: ;  // NOP and CGRAM address: accepted, only the busy time applies
                endcase
            end else if (rd_data_txn) begin
                ac <= ac_step(ac, id);
            end
        end
    end

    // Read-back follows the synchronized bus for as long as E stays high.
    assign doe          = e_sync & rw_sync;
    assign bus.lcd_doe  = doe;
    assign bus.lcd_dout = !doe    ? 8'h00 :
                          rs_sync ? ddram[ac] :
                                    {busy, ac[4], 2'b00, ac[3:0]};

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40, meaning busy duration in clk cycles after any accepted non-clear write.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 64, meaning total busy duration of Clear Display (SHALL be >=33).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports lcd_rs, lcd_rw, lcd_e (input, 1 each) and lcd_data (input, 8): HD44780-style bus from lcd_driver, asynchronous to clk.
REQ-006 SHALL have ports lcd_dout (output, 8) and lcd_doe (output, 1): read-back data and its enable.
REQ-007 SHALL have ports disp_addr (input, 5) and disp_char (output, 8): character-buffer read port, index = {line, col[3:0]}.
REQ-008 SHALL have 1-bit outputs busy, disp_on, cursor_on, blink_on, two_line, overrun, addr_err, and 5-bit output cursor_addr (current AC index).

Function
REQ-009 SHALL pass lcd_e, lcd_rs, lcd_rw and lcd_data through 2-flop synchronizers; a transaction is a 1->0 transition of synced lcd_e, using rs/rw/data sampled on the last cycle synced e was 1.
REQ-010 SHALL hold a 32x8 DDRAM; index 0-15 = line 0 (0x00-0x0F), 16-31 = line 1 (0x40-0x4F).
REQ-011 SHALL decode writes (rw=0, rs=0) by highest set bit of data: 0x01 clear; 0x02-03 home (AC=0); 0x04-07 entry mode (ID=bit1, shift bit stored, unused); 0x08-0F display control (disp_on=bit2, cursor_on=bit1, blink_on=bit0); 0x10-1F shift (bit3=0: AC+1 if bit2 else AC-1; bit3=1: no AC change); 0x20-3F function set (two_line=bit3); 0x40-7F CGRAM address, ignored; 0x80-FF DDRAM address.
REQ-012 SHALL on DDRAM address load AC={data[6],data[3:0]} when data[5:4]==0, else leave AC unchanged and set sticky addr_err.
REQ-013 SHALL on data write (rw=0, rs=1) store data at DDRAM[AC], then step AC by +1 (ID=1) or -1 (ID=0) modulo 32 (31->0, 0->31, 15->16 linear).
REQ-014 SHALL on read (rw=1) drive lcd_doe=1 and lcd_dout={busy, line, 2'b00, col} (rs=0) or DDRAM[AC] (rs=1, then AC steps per REQ-013), while synced lcd_e=1; lcd_doe=0 otherwise.
REQ-015 SHALL use FSM IDLE/BUSY/CLEAR: IDLE accepts transactions; any accepted write (incl. ignored CGRAM) -> BUSY for BUSY_CYCLES then IDLE; clear -> CLEAR.
REQ-016 SHALL in CLEAR write 0x20 to DDRAM[n] on cycle n (n=0..31), set AC=0, ID=1, then stay busy until CLEAR_CYCLES total have elapsed, then IDLE.
REQ-017 SHALL assert busy=1 in BUSY and CLEAR, 0 in IDLE.
REQ-018 SHALL drop writes arriving while busy=1 with no state change and set sticky overrun; reads SHALL be serviced in any state, and a rs=1 read during CLEAR returns current DDRAM contents.
REQ-019 SHALL register disp_char=DDRAM[disp_addr] with 1-cycle latency; a same-cycle DDRAM write to that index is visible the following cycle.
REQ-020 SHALL clear overrun and addr_err only by reset.

Reset
REQ-021 SHALL on rst=0, at any time including mid-CLEAR, immediately force: state IDLE, busy=0, all DDRAM=0x20, AC=0, ID=1, disp_on=cursor_on=blink_on=two_line=0, overrun=addr_err=0, lcd_doe=0, lcd_dout=0, disp_char=0x20, synchronizers=0.
REQ-022 SHALL not detect a transaction on the first falling edge after reset unless synced lcd_e was 1 for >=1 cycle post-reset.

Structure
REQ-023 SHALL place command opcode masks, space char 0x20, DDRAM size 32 and FSM state encoding in shared package lcd_pkg.
REQ-024 SHALL implement the REQ-009 synchronizer and edge detector as sub-module lcd_bus_sync.

Verification
REQ-025 Reset, write 0x80, data 0x31,0x32 -> disp_char[0]=0x31, [1]=0x32, cursor_addr=2, busy high 40 cycles after each write.
REQ-026 Write 0xC5, then data 0x41 -> DDRAM[21]=0x41, cursor_addr=22; write 0xA0 -> addr_err=1, cursor_addr unchanged 22.
REQ-027 AC=31, ID=1, data 0x5A -> DDRAM[31]=0x5A, AC=0; entry 0x04, AC=0, data 0x5B -> DDRAM[0]=0x5B, AC=31.
REQ-028 Fill DDRAM, write 0x01 -> 32 cycles later all 0x20, AC=0, busy for 64 cycles; data write at cycle 10 -> dropped, overrun=1.
REQ-029 rw=1, rs=0 during BUSY with AC=0x13 -> lcd_dout=0xC3 while lcd_e high; rs=1 -> DDRAM[19], AC=20.
REQ-030 Assert rst at cycle 5 of CLEAR -> all outputs at REQ-021 values immediately; next command accepted normally.
